// File: rtl/alu_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : alu_pkg                                                     |
// | Brief  : Op codes, flag bit positions and condition codes shared by  |
// |          the ALU issue block and its combinational ALU.              |
// | Rev    : 1.0                                                         |
// +----------------------------------------------------------------------+
package alu_pkg;

  typedef enum logic [2:0] {
    OP_PLUS  = 3'd0,
    OP_MINUS = 3'd1,
    OP_AND   = 3'd2,
    OP_OR    = 3'd3,
    OP_XOR   = 3'd4,
    OP_SHL   = 3'd5,
    OP_SHR   = 3'd6,
    OP_SAR   = 3'd7
  } alu_op_e;

  // Flag word is {C,V,S,Z}
  localparam int FLAG_C = 3;
  localparam int FLAG_V = 2;
  localparam int FLAG_S = 1;
  localparam int FLAG_Z = 0;

  typedef enum logic [2:0] {
    COND_ALWAYS = 3'd0,
    COND_Z      = 3'd1,
    COND_NZ     = 3'd2,
    COND_C      = 3'd3,
    COND_NC     = 3'd4,
    COND_S      = 3'd5,
    COND_V      = 3'd6,
    COND_SXV    = 3'd7
  } cond_e;

  // Evaluate a condition code against a flag word
  function automatic logic eval_cond(input logic [2:0] c, input logic [3:0] f);
    logic r;
    r = 1'b0;
    case (cond_e'(c))
      COND_ALWAYS: r = 1'b1;
      COND_Z:      r = f[FLAG_Z];
      COND_NZ:     r = ~f[FLAG_Z];
      COND_C:      r = f[FLAG_C];
      COND_NC:     r = ~f[FLAG_C];
      COND_S:      r = f[FLAG_S];
      COND_V:      r = f[FLAG_V];
      COND_SXV:    r = f[FLAG_S] ^ f[FLAG_V];
      default:     r = 1'b0;
    endcase
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/alu.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : alu                                                         |
// | Brief  : 16-bit combinational ALU producing a result and {C,V,S,Z}.  |
// | Rev    : 1.0                                                         |
// +----------------------------------------------------------------------+
module alu
  import alu_pkg::*;
(
  input  logic [2:0]  sel,
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic [15:0] result,
  output logic [3:0]  flags
);

  logic [16:0] sum;
  logic [16:0] diff;
  logic [3:0]  shamt;

  assign sum   = {1'b0, a} + {1'b0, b};
  assign diff  = {1'b0, a} - {1'b0, b};
  assign shamt = b[3:0];

  // Operation select plus flag generation; logic ops never set C or V
  always_comb begin
    result = 16'd0;
    flags  = 4'd0;
    case (alu_op_e'(sel))
      OP_PLUS: begin
        result        = sum[15:0];
        flags[FLAG_C] = sum[16];
        flags[FLAG_V] = (a[15] == b[15]) && (sum[15] != a[15]);
      end
      OP_MINUS: begin
        result        = diff[15:0];
        // diff[16] set means the subtraction borrowed (a < b unsigned)
        flags[FLAG_C] = diff[16];
        flags[FLAG_V] = (a[15] != b[15]) && (diff[15] != a[15]);
      end
      OP_AND:  result = a & b;
      OP_OR:   result = a | b;
      OP_XOR:  result = a ^ b;
      OP_SHL:  result = a << shamt;
      OP_SHR:  result = a >> shamt;
      OP_SAR:  result = $unsigned($signed(a) >>> shamt);
      default: result = 16'd0;
    endcase
    flags[FLAG_S] = result[15];
    flags[FLAG_Z] = (result == 16'd0);
  end

endmodule
`default_nettype wire

// File: rtl/alu_issue.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : alu_issue                                                   |
// | Brief  : Accepts ALU requests, computes them in one pass, queues the |
// |          results in a 2-entry FIFO and keeps a condition-flag reg.   |
// | Rev    : 1.0                                                         |
// +----------------------------------------------------------------------+
module alu_issue
  import alu_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [2:0]  in_sel,
  input  logic [15:0] in_a,
  input  logic [15:0] in_b,
  input  logic [3:0]  in_tag,
  input  logic        in_setf,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] out_result,
  output logic [3:0]  out_flags,
  output logic [3:0]  out_tag,
  input  logic [2:0]  cond,
  output logic        cond_true,
  output logic [3:0]  flags_q
);

  logic [15:0] alu_result;
  logic [3:0]  alu_flags;

  logic [15:0] mem_result [2];
  logic [3:0]  mem_flags  [2];
  logic [3:0]  mem_tag    [2];
  logic        wr_ptr;
  logic        rd_ptr;
  logic [1:0]  count;
  logic        push;
  logic        pop;

  alu u_alu (
    .sel    (in_sel),
    .a      (in_a),
    .b      (in_b),
    .result (alu_result),
    .flags  (alu_flags)
  );

  // Handshake is derived from count only, so out_ready never reaches in_ready
  assign in_ready  = (count < 2'd2);
  assign out_valid = (count != 2'd0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  assign out_result = mem_result[rd_ptr];
  assign out_flags  = mem_flags[rd_ptr];
  assign out_tag    = mem_tag[rd_ptr];

  // Storage is cleared on reset so the head fields read as zero
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 2; i++) begin
        mem_result[i] <= 16'd0;
        mem_flags[i]  <= 4'd0;
        mem_tag[i]    <= 4'd0;
      end
    end else if (push) begin
      mem_result[wr_ptr] <= alu_result;
      mem_flags[wr_ptr]  <= alu_flags;
      mem_tag[wr_ptr]    <= in_tag;
    end
  end

  // Pointers and occupancy; 1-bit pointers wrap naturally from 1 to 0
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) wr_ptr <= ~wr_ptr;
      if (pop)  rd_ptr <= ~rd_ptr;
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  // Flag register follows acceptance, not the FIFO drain
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      flags_q <= 4'd0;
    end else if (push && in_setf) begin
      flags_q <= alu_flags;
    end
  end

  // Condition evaluation against the architectural flags
  always_comb begin
    cond_true = eval_cond(cond, flags_q);
  end

endmodule
`default_nettype wire

// File: tb/tb_alu_issue.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : tb_alu_issue                                                |
// | Brief  : Directed and randomized self-checking bench for alu_issue.  |
// | Rev    : 1.0                                                         |
// +----------------------------------------------------------------------+
module tb_alu_issue;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [2:0]  in_sel = 3'd0;
  logic [15:0] in_a = 16'd0;
  logic [15:0] in_b = 16'd0;
  logic [3:0]  in_tag = 4'd0;
  logic        in_setf = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [15:0] out_result;
  logic [3:0]  out_flags;
  logic [3:0]  out_tag;
  logic [2:0]  cond = 3'd0;
  logic        cond_true;
  logic [3:0]  flags_q;

  int checks = 0;
  int errors = 0;

  // Reference state: queue of {flags, tag, result} and the flag register
  logic [23:0] mq[$];
  logic [3:0]  mflags = 4'd0;

  alu_issue dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_sel     (in_sel),
    .in_a       (in_a),
    .in_b       (in_b),
    .in_tag     (in_tag),
    .in_setf    (in_setf),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_flags  (out_flags),
    .out_tag    (out_tag),
    .cond       (cond),
    .cond_true  (cond_true),
    .flags_q    (flags_q)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Integer-arithmetic ALU: returns {flags, result}
  function automatic logic [19:0] model_alu(input int sel, input int a, input int b);
    int sa, sb, r, n, s;
    bit c, v;
    logic [15:0] res;
    sa = (a >= 32768) ? a - 65536 : a;
    sb = (b >= 32768) ? b - 65536 : b;
    n  = b % 16;
    c  = 0;
    v  = 0;
    case (sel)
      0: begin r = a + b; c = (r > 65535); s = sa + sb; v = (s > 32767) || (s < -32768); end
      1: begin r = a - b; c = (a < b);     s = sa - sb; v = (s > 32767) || (s < -32768); end
      2: r = a & b;
      3: r = a | b;
      4: r = a ^ b;
      5: r = a << n;
      6: r = a >> n;
      default: r = sa >>> n;
    endcase
    r   = r & 65535;
    res = r[15:0];
    return {c, v, res[15], (res == 16'd0), res};
  endfunction

  function automatic bit model_cond(input int c, input logic [3:0] f);
    case (c)
      0: return 1'b1;
      1: return f[0];
      2: return !f[0];
      3: return f[3];
      4: return !f[3];
      5: return f[1];
      6: return f[2];
      default: return f[1] ^ f[2];
    endcase
  endfunction

  task automatic compare();
    chk("in_ready", in_ready, (mq.size() < 2));
    chk("out_valid", out_valid, (mq.size() != 0));
    chk("flags_q", flags_q, mflags);
    chk("cond_true", cond_true, model_cond(cond, mflags));
    if (mq.size() != 0) begin
      chk("out_result", out_result, mq[0][15:0]);
      chk("out_tag", out_tag, mq[0][19:16]);
      chk("out_flags", out_flags, mq[0][23:20]);
    end
  endtask

  // One clock: update the model on the edge, compare on the falling edge
  task automatic cycle();
    logic [19:0] fr;
    bit acc;
    @(posedge clk);
    if (!rst) begin
      acc = in_valid && (mq.size() < 2);
      if (mq.size() != 0 && out_ready) void'(mq.pop_front());
      if (acc) begin
        fr = model_alu(in_sel, in_a, in_b);
        mq.push_back({fr[19:16], in_tag, fr[15:0]});
        if (in_setf) mflags = fr[19:16];
      end
    end
    @(negedge clk);
    if (!rst) compare();
  endtask

  task automatic drive(input logic v, input logic [2:0] s, input logic [15:0] a,
                       input logic [15:0] b, input logic [3:0] t, input logic f);
    in_valid = v; in_sel = s; in_a = a; in_b = b; in_tag = t; in_setf = f;
  endtask

  function automatic logic [15:0] pick();
    case ($urandom_range(0, 7))
      0: return 16'h0000;
      1: return 16'h0001;
      2: return 16'h7FFF;
      3: return 16'h8000;
      4: return 16'hFFFF;
      default: return 16'($urandom);
    endcase
  endfunction

  initial begin
    // Reset state
    #1;
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_in_ready", in_ready, 1'b1);
    chk("rst_flags_q", flags_q, 4'b0000);
    chk("rst_out_result", out_result, 16'h0000);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    out_ready = 1'b1;

    // PLUS FFFF + 1 with setf: zero result and carry
    cond = 3'd1;
    drive(1, 3'd0, 16'hFFFF, 16'h0001, 4'd5, 1);
    cycle();
    chk("plus_wrap_result", out_result, 16'h0000);
    chk("plus_wrap_flags", out_flags, 4'b1001);
    chk("plus_wrap_flags_q", flags_q, 4'b1001);
    chk("plus_wrap_cond_z", cond_true, 1'b1);

    // PLUS 7FFF + 7FFF: signed overflow, S^V clear
    cond = 3'd7;
    drive(1, 3'd0, 16'h7FFF, 16'h7FFF, 4'd6, 1);
    cycle();
    chk("plus_ovf_result", out_result, 16'hFFFE);
    chk("plus_ovf_flags", out_flags, 4'b0110);
    chk("plus_ovf_cond_sxv", cond_true, 1'b0);

    // MINUS pair in order with tags
    drive(1, 3'd1, 16'd30, 16'd40, 4'd3, 0);
    cycle();
    chk("minus1_result", out_result, 16'hFFF6);
    chk("minus1_flags", out_flags, 4'b1010);
    chk("minus1_tag", out_tag, 4'd3);
    drive(1, 3'd1, 16'h8000, 16'h0001, 4'd4, 0);
    cycle();
    chk("minus2_result", out_result, 16'h7FFF);
    chk("minus2_flags", out_flags, 4'b0100);
    chk("minus2_tag", out_tag, 4'd4);
    drive(0, 3'd0, 16'd0, 16'd0, 4'd0, 0);
    cycle();

    // Backpressure: fill, hold, single pop pulse
    out_ready = 1'b0;
    drive(1, 3'd2, 16'hF0F0, 16'h0FF0, 4'd7, 0);
    cycle();
    drive(1, 3'd3, 16'h1200, 16'h0034, 4'd8, 0);
    cycle();
    drive(1, 3'd4, 16'hAAAA, 16'hFFFF, 4'd9, 0);
    chk("full_in_ready", in_ready, 1'b0);
    cycle();
    chk("full_hold_ready", in_ready, 1'b0);
    chk("full_hold_result", out_result, 16'h00F0);
    chk("full_hold_tag", out_tag, 4'd7);
    out_ready = 1'b1;
    cycle();
    out_ready = 1'b0;
    chk("pop_in_ready", in_ready, 1'b1);
    chk("pop_head_tag", out_tag, 4'd8);
    cycle();
    drive(0, 3'd0, 16'd0, 16'd0, 4'd0, 0);
    out_ready = 1'b1;
    cycle();
    chk("third_tag", out_tag, 4'd9);
    chk("third_result", out_result, 16'h5555);
    cycle();

    // SAR without flag update
    drive(1, 3'd7, 16'hC000, 16'h0003, 4'd2, 0);
    cycle();
    chk("sar_result", out_result, 16'hF800);
    chk("sar_flags", out_flags, 4'b0010);
    chk("sar_flags_q_kept", flags_q, 4'b0110);
    drive(0, 3'd0, 16'd0, 16'd0, 4'd0, 0);
    cycle();

    // Asynchronous reset with two entries queued
    out_ready = 1'b0;
    drive(1, 3'd0, 16'h0001, 16'h0002, 4'd1, 1);
    cycle();
    drive(1, 3'd0, 16'h0003, 16'h0004, 4'd2, 1);
    cycle();
    #2 rst = 1'b1;
    #1;
    chk("arst_out_valid", out_valid, 1'b0);
    chk("arst_flags_q", flags_q, 4'b0000);
    chk("arst_in_ready", in_ready, 1'b1);
    mq.delete();
    mflags = 4'd0;
    cycle();
    rst = 1'b0;
    drive(0, 3'd0, 16'd0, 16'd0, 4'd0, 0);
    cycle();
    chk("arst_dropped", out_valid, 1'b0);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      drive(($urandom_range(0, 3) != 0), 3'($urandom), pick(), pick(),
            4'($urandom), 1'($urandom));
      out_ready = ($urandom_range(0, 2) != 0);
      cond = 3'($urandom);
      cycle();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/alu_issue.md
ALU_ISSUE -- requirements
Module: alu_issue

Interface
- REQ-001: The block SHALL have exactly one clock and one reset, and reset SHALL be asynchronous and active-high.
- REQ-002: clk  input  1  the single clock; all state SHALL update on its rising edge.
- REQ-003: rst  input  1  asynchronous, active-high reset.
- REQ-004: in_valid  input  1  request present.
- REQ-005: in_ready  output  1  request can be accepted; it is high when FIFO count < 2.
- REQ-006: in_sel  input  3  op: 0 PLUS, 1 MINUS, 2 AND, 3 OR, 4 XOR, 5 SHL, 6 SHR, 7 SAR.
- REQ-007: in_a, in_b  input  16 each  operands; for shifts, b[3:0] is the shift amount.
- REQ-008: in_tag  input  4  opaque ID; it SHALL be returned unchanged with the result.
- REQ-009: in_setf  input  1  when high, the request SHALL update the flags register.
- REQ-010: out_valid  output  1  a result is at the FIFO head.
- REQ-011: out_ready  input  1  consumer accepts the head.
- REQ-012: out_result  output  16  head result.
- REQ-013: out_flags  output  4  head flags, ordered {C,V,S,Z} (bit3 to bit0).
- REQ-014: out_tag  output  4  head tag.
- REQ-015: cond  input  3  condition select: 0 always, 1 Z, 2 !Z, 3 C, 4 !C, 5 S, 6 V, 7 S^V.
- REQ-016: cond_true  output  1  cond evaluated against the flags register.
- REQ-017: flags_q  output  4  flags register contents.

Function
- REQ-018: A request SHALL be accepted on a rising edge where in_valid && in_ready.
- REQ-019: The result, flags and tag SHALL be computed combinationally by the alu sub-module and written into the 2-entry FIFO on that edge.
- REQ-020: out_valid SHALL rise on the edge following acceptance into an empty FIFO, giving a latency of 1.
- REQ-021: PLUS/MINUS flags: C = carry-out (PLUS) or borrow (MINUS); V = signed overflow; S = result[15]; Z = (result == 0).
- REQ-022: AND/OR/XOR/SHL/SHR/SAR flags: C = 0 and V = 0; S and Z come from the result.
- REQ-023: Shift amounts 0..15 SHALL be honoured; SAR SHALL replicate bit 15.
- REQ-024: All arithmetic SHALL be modulo 2^16.
- REQ-025: The FIFO head SHALL be popped on an edge where out_valid && out_ready.
- REQ-026: Output fields SHALL be held stable while out_valid && !out_ready.
- REQ-027: A simultaneous push and pop with count 1 SHALL leave count at 1, with the new entry becoming the head on the next cycle.
- REQ-028: A simultaneous push and pop with count 0 is impossible; the pushed entry becomes the head.
- REQ-029: In the full state (count 2), in_ready SHALL be 0, and a pop SHALL raise in_ready on the next cycle.
- REQ-030: in_ready SHALL depend only on registered state, with no combinational path from out_ready.
- REQ-031: FIFO read/write pointers SHALL be 1 bit wide and wrap 1 -> 0.
- REQ-032: flags_q SHALL load the computed flags on the acceptance edge when in_setf = 1, independent of FIFO pop timing.
- REQ-033: cond_true SHALL be combinational from cond and flags_q only; a request accepted with in_setf = 1 is visible to cond_true on the following cycle.

Reset
- REQ-034: When rst is asserted, the block SHALL immediately clear count, both pointers, out_valid, out_result, out_flags, out_tag and flags_q to 0, discarding queued entries.
- REQ-035: in_ready SHALL be 1 while and after rst, since count = 0.
- REQ-036: A request presented on the edge where rst is high SHALL be dropped.
- REQ-037: Release of rst SHALL be assumed synchronous to clk by the system; no internal synchronizer is required.

Structure
- REQ-038: Shared package alu_pkg SHALL hold the op encodings (PLUS..SAR), flag bit indices (C = 3, V = 2, S = 1, Z = 0) and condition encodings.
- REQ-039: One sub-module SHALL be instantiated: the existing combinational alu (ports sel, a, b, result, flags).
- REQ-040: The FIFO and the condition logic SHALL be implemented inline.

Verification
- REQ-041: Push PLUS a = 0xFFFF, b = 1, setf = 1, with out_ready = 1 -> one cycle later: out_result 0x0000, out_flags 1001, flags_q 1001; cond = 1 gives cond_true = 1.
- REQ-042: Push PLUS 0x7FFF + 0x7FFF -> out_result 0xFFFE, flags 0110; cond = 7 gives cond_true = 0 (S^V = 0).
- REQ-043: Push MINUS 30 - 40, then MINUS 0x8000 - 1 -> results 0xFFF6 with flags 1010, then 0x7FFF with flags 0100, in order, with tags preserved.
- REQ-044: Hold out_ready = 0 and push 3 requests -> 2 accepted, in_ready = 0 with outputs stable; then pulse out_ready for 1 cycle -> in_ready = 1 on the next cycle, and the third request is accepted and exits after the second.
- REQ-045: Push SAR 0xC000 by 3 with setf = 0 -> result 0xF800, flags 0010, and flags_q unchanged from its previous value.
- REQ-046: Assert rst mid-stream with 2 entries queued -> out_valid = 0, flags_q = 0000 and in_ready = 1 immediately, before the next clk edge.
